piso_multi_bit_sreg: RTL and testbench

Parallel-in, serial-out multi-bit shift register. It is the transmit-side counterpart of the static multi-bit delay line: it accepts DEPTH words of WIDTH bits in one load handshake and emits them one word per enabled clock on `so`. It sits upstream of serial word consumers and feeds stimulus for clock-enabled shift chains.

---
 rtl/sreg_pkg.sv | 23 ++
 rtl/word_counter.sv | 52 +++++
 rtl/piso_multi_bit_sreg.sv | 108 ++++++++++
 tb/tb_piso_multi_bit_sreg.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/sreg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sreg_pkg
// Description : Types and helpers shared by the multi-bit shift-register
//               family. It provides the PISO state enum and the word-counter
//               width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package sreg_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_e;

    // Width of a counter that indexes DEPTH words. A counter always has at
    // least one bit, so that the DEPTH<=2 cases are still legal vectors.
    function automatic int cnt_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage : sreg_pkg
`default_nettype wire

// File: rtl/word_counter.sv
`default_nettype none
// ============================================================================
// Module      : word_counter
// Description : Mod-DEPTH word counter. It is shared by the PISO shift
//               register and by other sequencers.
// Ports       : clk    - rising-edge clock
//               rst_n  - asynchronous active-low reset
//               clr    - synchronous clear to 0 (has priority over en)
//               en     - advance by one, wrapping to 0 after DEPTH-1
//               cnt    - current count
//               at_max - count equals DEPTH-1
// Revision    : 1.0 - initial release
// ============================================================================
module word_counter #(
    parameter int DEPTH = 4,
    parameter int CW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          at_max
);

    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt    = cnt_q;
    assign at_max = (cnt_q == CNT_MAX);

endmodule : word_counter
`default_nettype wire

// File: rtl/piso_multi_bit_sreg.sv
`default_nettype none
// ============================================================================
// Module      : piso_multi_bit_sreg
// Description : Parallel-in, serial-out multi-bit shift register. It accepts
//               DEPTH words of WIDTH bits in one load and emits one word per
//               enabled clock. Word 0 is emitted first.
// Ports       : clk      - rising-edge clock
//               rst_n    - asynchronous active-low reset
//               ld_valid - parallel load request
//               ld_ready - a load can be accepted this cycle
//               pi       - parallel words, word i = pi[i*WIDTH +: WIDTH]
//               ce       - consumer takes the current so word on this edge
//               so       - current serial word
//               so_valid - so holds an unconsumed word
//               so_last  - so is the final word of the current load
// Revision    : 1.0 - initial release
// ============================================================================
module piso_multi_bit_sreg
    import sreg_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic [DEPTH*WIDTH-1:0] pi,
    input  logic                   ce,
    output logic [WIDTH-1:0]       so,
    output logic                   so_valid,
    output logic                   so_last
);

    localparam int            CW      = cnt_width(DEPTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH - 1);

    piso_state_e              state_q;
    piso_state_e              state_d;
    logic [DEPTH*WIDTH-1:0]   sreg_q;
    logic [DEPTH*WIDTH-1:0]   sreg_d;
    logic [CW-1:0]            cnt_q;
    logic                     cnt_at_max;
    logic                     load;
    logic                     shift;

    // ------------------------------------------------------------------
    // State and data registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
        end
    end

    // A load clears the counter, so a load on the last word restarts at
    // word 0 instead of wrapping through the shift path.
    word_counter #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_word_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (load),
        .en     (shift),
        .cnt    (cnt_q),
        .at_max (cnt_at_max)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        load    = ld_valid && ld_ready;
        shift   = (state_q == SHIFT) && ce;
        state_d = state_q;
        sreg_d  = sreg_q;
        if (load) begin
            // A load wins over a shift on the same edge. The outgoing last
            // word still counts as consumed, because ld_ready required ce.
            state_d = SHIFT;
            sreg_d  = pi;
        end else if (shift) begin
            sreg_d = sreg_q >> WIDTH;
            if (cnt_at_max) begin
                state_d = IDLE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        so       = sreg_q[WIDTH-1:0];
        so_valid = (state_q == SHIFT);
        so_last  = (state_q == SHIFT) && (cnt_q == CNT_MAX);
        // ld_ready is independent of ld_valid. This keeps the handshake free
        // of combinational loops with the requester.
        ld_ready = (state_q == IDLE) || (so_last && ce);
    end

endmodule : piso_multi_bit_sreg
`default_nettype wire

// File: tb/tb_piso_multi_bit_sreg.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_multi_bit_sreg
// Description : Self-checking bench for piso_multi_bit_sreg (DEPTH=4,
//               WIDTH=4). The reference is a queue of words that are still
//               to be sent.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_multi_bit_sreg;

    localparam int DEPTH = 4;
    localparam int WIDTH = 4;

    logic                   clk;
    logic                   rst_n;
    logic                   ld_valid;
    logic                   ld_ready;
    logic [DEPTH*WIDTH-1:0] pi;
    logic                   ce;
    logic [WIDTH-1:0]       so;
    logic                   so_valid;
    logic                   so_last;

    int total = 0;
    int bad   = 0;

    // Words that are still to be sent; entry 0 is the word currently on so.
    logic [WIDTH-1:0] q[$];

    piso_multi_bit_sreg #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .pi       (pi),
        .ce       (ce),
        .so       (so),
        .so_valid (so_valid),
        .so_last  (so_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare all outputs against the queue model for the current inputs.
    task automatic check_outs(input string tag);
        logic [WIDTH-1:0] e_so;
        e_so = (q.size() > 0) ? q[0] : '0;
        chk({tag, ".so"},       32'(so),       32'(e_so));
        chk({tag, ".so_valid"}, 32'(so_valid), 32'(q.size() > 0));
        chk({tag, ".so_last"},  32'(so_last),  32'(q.size() == 1));
        chk({tag, ".ld_ready"}, 32'(ld_ready),
            32'((q.size() == 0) || (q.size() == 1 && ce)));
    endtask

    // One clock: drive inputs, check before the edge, advance the model.
    task automatic cycle(input string tag, input logic v,
                         input logic [DEPTH*WIDTH-1:0] p, input logic c);
        logic accept;
        ld_valid = v;
        pi       = p;
        ce       = c;
        #1;
        check_outs(tag);
        accept = v && ((q.size() == 0) || (q.size() == 1 && c));
        @(posedge clk);
        if (accept) begin
            q.delete();
            for (int i = 0; i < DEPTH; i++) q.push_back(p[i*WIDTH +: WIDTH]);
        end else if (q.size() > 0 && c) begin
            void'(q.pop_front());
        end
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        ld_valid = 1'b0;
        pi       = '0;
        ce       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset");
        rst_n = 1'b1;

        // Basic drain
        cycle("drain.ld", 1'b1, 16'h4321, 1'b1);
        chk("drain.first", 32'(so), 32'h1);
        for (int i = 0; i < 5; i++) cycle("drain", 1'b0, 16'h0, 1'b1);
        chk("drain.end_so", 32'(so), 32'h0);

        // Enable gaps
        cycle("gap.ld", 1'b1, 16'hA5C3, 1'b0);
        begin
            logic [6:0] pat;
            pat = 7'b1011001;  // bit 0 first: 1,0,0,1,1,0,1
            for (int i = 0; i < 7; i++) cycle("gap", 1'b0, 16'h0, pat[i]);
        end
        chk("gap.done", 32'(so_valid), 32'h0);

        // Back-to-back loads
        cycle("b2b.ld0", 1'b1, 16'h8765, 1'b1);
        for (int i = 0; i < 3; i++) cycle("b2b.a", 1'b0, 16'h0, 1'b1);
        chk("b2b.last8", 32'(so), 32'h8);
        cycle("b2b.ld1", 1'b1, 16'hFEDC, 1'b1);
        chk("b2b.noGap", 32'(so), 32'hC);
        for (int i = 0; i < 4; i++) cycle("b2b.b", 1'b0, 16'h0, 1'b1);

        // Busy reject
        cycle("busy.ld", 1'b1, 16'h1111, 1'b0);
        cycle("busy.rej", 1'b1, 16'h2222, 1'b0);
        for (int i = 0; i < 4; i++) cycle("busy.hold", 1'b1, 16'h2222, 1'b1);
        chk("busy.new", 32'(so), 32'h2);
        for (int i = 0; i < 4; i++) cycle("busy.drain", 1'b0, 16'h0, 1'b1);

        // Reset mid-stream, asserted between edges
        cycle("rst.ld", 1'b1, 16'h9ABC, 1'b1);
        cycle("rst.w0", 1'b0, 16'h0, 1'b1);
        cycle("rst.w1", 1'b0, 16'h0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        check_outs("rst.async");
        rst_n = 1'b1;
        cycle("rst.ld2", 1'b1, 16'h0F0F, 1'b1);
        for (int i = 0; i < 4; i++) cycle("rst.drain", 1'b0, 16'h0, 1'b1);

        // Idle enable toggling
        for (int i = 0; i < 10; i++) cycle("idle", 1'b0, 16'h0, 1'(i % 2));

        // Randomized traffic against the queue model
        for (int i = 0; i < 300; i++) begin
            cycle("rand", 1'($urandom_range(0, 1)), 16'($urandom),
                  1'($urandom_range(0, 3) != 0));
        end
        check_outs("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_piso_multi_bit_sreg
`default_nettype wire
